// File: rtl/zoom_pkg.sv
// Definitions shared by the zoom engines: default frame geometry, the
// engine FSM states and small elaboration-time helpers.
package zoom_pkg;

    localparam int unsigned FRAME_W = 320;
    localparam int unsigned FRAME_H = 240;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_FINISH
    } zoom_state_e;

    // Ceiling log2; exact for the power-of-two factors the engines use.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Offset that centres an out-sized span inside a src-sized span.
    function automatic int unsigned centre_off(input int unsigned src, input int unsigned out);
        return (src - out) / 2;
    endfunction

endpackage

// File: rtl/block_accumulator.sv
// Sums the samples of one block and presents the truncated average.
module block_accumulator
    import zoom_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned SHIFT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [PIX_W-1:0] data_i,
    output logic [PIX_W-1:0] avg_o
);

    localparam int unsigned ACC_W = PIX_W + SHIFT;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    assign sum = acc_q + ACC_W'(data_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Includes the sample on data_i, so the caller can register the final
    // average on the same edge as the last add.
    assign avg_o = sum[ACC_W-1:SHIFT];

endmodule

// File: rtl/block_average_downscaler.sv
// Zoom-out engine: clears the framebuffer, then writes the FACTOR x FACTOR
// block averages of the source image centred in the framebuffer.
module block_average_downscaler
    import zoom_pkg::*;
#(
    parameter int unsigned SRC_W  = FRAME_W,
    parameter int unsigned SRC_H  = FRAME_H,
    parameter int unsigned FACTOR = 2,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_rd_en,
    input  logic [PIX_W-1:0]  src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data,
    output logic              dst_wr_en
);

    localparam int unsigned OUT_W = SRC_W / FACTOR;
    localparam int unsigned OUT_H = SRC_H / FACTOR;
    localparam int unsigned X_OFF = centre_off(SRC_W, OUT_W);
    localparam int unsigned Y_OFF = centre_off(SRC_H, OUT_H);
    localparam int unsigned K     = FACTOR * FACTOR;
    localparam int unsigned SHIFT = 2 * log2c(FACTOR);
    localparam int unsigned XW    = log2c(OUT_W);
    localparam int unsigned YW    = log2c(OUT_H);
    localparam int unsigned KW    = SHIFT;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SRC_W * SRC_H - 1);
    localparam logic [XW-1:0]     OX_LAST  = XW'(OUT_W - 1);
    localparam logic [YW-1:0]     OY_LAST  = YW'(OUT_H - 1);
    localparam logic [KW-1:0]     K_LAST   = KW'(K - 1);

    zoom_state_e       state_q, state_d;
    logic [XW-1:0]     ox_q, ox_d;
    logic [YW-1:0]     oy_q, oy_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] clr_q, clr_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              src_rd_en_q, src_rd_en_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              dst_wr_en_q, dst_wr_en_d;
    logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic [PIX_W-1:0]  dst_data_q, dst_data_d;

    logic              acc_clr;
    logic              acc_add;
    logic [PIX_W-1:0]  avg;

    function automatic logic [ADDR_W-1:0] src_index(input logic [XW-1:0] ox,
                                                    input logic [YW-1:0] oy,
                                                    input logic [KW-1:0] k);
        int unsigned dx;
        int unsigned dy;
        dx = 32'(k) % FACTOR;
        dy = 32'(k) / FACTOR;
        return ADDR_W'((32'(oy) * FACTOR + dy) * SRC_W + 32'(ox) * FACTOR + dx);
    endfunction

    function automatic logic [ADDR_W-1:0] dst_index(input logic [XW-1:0] ox,
                                                    input logic [YW-1:0] oy);
        return ADDR_W'((32'(oy) + Y_OFF) * SRC_W + 32'(ox) + X_OFF);
    endfunction

    // Read data lags src_rd_en by one cycle: clear on the first READ cycle,
    // then add the previous cycle's sample through DRAIN.
    assign acc_clr = (state_q == S_READ) && (k_q == '0);
    assign acc_add = ((state_q == S_READ) && (k_q != '0)) || (state_q == S_DRAIN);

    block_accumulator #(
        .PIX_W (PIX_W),
        .SHIFT (SHIFT)
    ) u_acc (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (acc_clr),
        .add_i  (acc_add),
        .data_i (src_data),
        .avg_o  (avg)
    );

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        k_d     = k_q;
        clr_d   = clr_q;

        case (state_q)
            S_IDLE: begin
                clr_d = '0;
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d = S_READ;
                    ox_d    = '0;
                    oy_d    = '0;
                    k_d     = '0;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            S_READ: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                k_d = '0;
                if ((ox_q == OX_LAST) && (oy_q == OY_LAST)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_READ;
                    if (ox_q == OX_LAST) begin
                        ox_d = '0;
                        oy_d = oy_q + 1'b1;
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are registered alongside the state they belong to.
        busy_d      = state_d inside {S_CLEAR, S_READ, S_DRAIN, S_WRITE};
        done_d      = (state_d == S_FINISH);
        src_rd_en_d = (state_d == S_READ);
        src_addr_d  = (state_d == S_READ) ? src_index(ox_d, oy_d, k_d) : '0;
        dst_wr_en_d = (state_d == S_CLEAR) || (state_d == S_WRITE);
        dst_addr_d  = '0;
        dst_data_d  = '0;
        if (state_d == S_CLEAR) begin
            dst_addr_d = clr_d;
        end else if (state_d == S_WRITE) begin
            dst_addr_d = dst_index(ox_d, oy_d);
            dst_data_d = avg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ox_q        <= '0;
            oy_q        <= '0;
            k_q         <= '0;
            clr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            src_rd_en_q <= 1'b0;
            src_addr_q  <= '0;
            dst_wr_en_q <= 1'b0;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            k_q         <= k_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            src_rd_en_q <= src_rd_en_d;
            src_addr_q  <= src_addr_d;
            dst_wr_en_q <= dst_wr_en_d;
            dst_addr_q  <= dst_addr_d;
            dst_data_q  <= dst_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign src_rd_en = src_rd_en_q;
    assign src_addr  = src_addr_q;
    assign dst_wr_en = dst_wr_en_q;
    assign dst_addr  = dst_addr_q;
    assign dst_data  = dst_data_q;

endmodule
